light_loc_sync: RTL and testbench

LIGHT_LOC_SYNC -- requirements
Module: light_loc_sync

---
 rtl/light_loc_sync.sv | 221 ++++++++++++++++++++++
 tb/tb_light_loc_sync.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/light_loc_sync.sv
// -----------------------------------------------------------------------------
// light_loc_sync
//
// Purpose
//   Holds per-channel (x, y, z) light positions. The host writes positions into
//   a shadow set; a frame boundary pulse transfers the whole shadow set into the
//   active set that drives the outputs. Every channel therefore changes on the
//   same edge, and all channels stay consistent within a frame.
//
// Configuration macro
//   LOC_SYNC_IMMEDIATE_EN : when defined, accepted writes go straight into the
//                           active set. There is no shadow set and no FSM, and
//                           frame_start_i is ignored.
//
// Parameters
//   LOC_WIDTH  : coordinate width per axis
//   N_LIGHTS   : number of light channels (1..16)
//   IDX_WIDTH  : channel index width (defaults to $clog2(N_LIGHTS), minimum 1)
//
// Ports
//   clk, rst_n            : clock; synchronous active-low reset
//   loc_x/y/z_i           : position being written
//   loc_idx_i             : target channel of the write
//   loc_vld_i / loc_rdy_o : write handshake (accepted when both are high)
//   frame_start_i         : one-cycle pulse at each frame boundary
//   loc_x/y/z_o           : active positions; channel k at [k*LOC_WIDTH +: LOC_WIDTH]
//   pending_o             : the shadow set holds uncommitted data
//   commit_o              : one-cycle pulse in the cycle after the active set loads
//   idx_err_o             : sticky; an out-of-range index was written (reset clears it)
// -----------------------------------------------------------------------------
module light_loc_sync #(
  parameter int LOC_WIDTH = 10,
  parameter int N_LIGHTS  = 4,
  parameter int IDX_WIDTH = (N_LIGHTS > 1) ? $clog2(N_LIGHTS) : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [LOC_WIDTH-1:0]          loc_x_i,
  input  logic [LOC_WIDTH-1:0]          loc_y_i,
  input  logic [LOC_WIDTH-1:0]          loc_z_i,
  input  logic [IDX_WIDTH-1:0]          loc_idx_i,
  input  logic                          loc_vld_i,
  output logic                          loc_rdy_o,
  input  logic                          frame_start_i,
  output logic [N_LIGHTS*LOC_WIDTH-1:0] loc_x_o,
  output logic [N_LIGHTS*LOC_WIDTH-1:0] loc_y_o,
  output logic [N_LIGHTS*LOC_WIDTH-1:0] loc_z_o,
  output logic                          pending_o,
  output logic                          commit_o,
  output logic                          idx_err_o
);

  typedef struct packed {
    logic [LOC_WIDTH-1:0] x;
    logic [LOC_WIDTH-1:0] y;
    logic [LOC_WIDTH-1:0] z;
  } pos_t;

  // The index is compared in a width that holds both the index and N_LIGHTS.
  // IDX_WIDTH may be overridden wider than needed, and the range check must
  // still see the full index value.
  localparam int CMP_W = (IDX_WIDTH + 1 > 6) ? IDX_WIDTH + 1 : 6;
  localparam logic [CMP_W-1:0] N_CMP = CMP_W'(N_LIGHTS);

  logic [CMP_W-1:0] idx_ext;
  logic             idx_ok;
  logic             wr_acc;  // handshake completed this cycle
  logic             wr_ok;   // accepted write with an in-range index
  pos_t             wr_pos;

  pos_t active_q [N_LIGHTS];
  pos_t active_d [N_LIGHTS];
  logic commit_q,  commit_d;
  logic idx_err_q, idx_err_d;

  assign idx_ext = CMP_W'(loc_idx_i);
  assign idx_ok  = (idx_ext < N_CMP);
  assign wr_acc  = loc_vld_i & loc_rdy_o;
  assign wr_ok   = wr_acc & idx_ok;
  assign wr_pos  = '{x: loc_x_i, y: loc_y_i, z: loc_z_i};

  // An out-of-range write is never forgotten; only reset clears the flag.
  assign idx_err_d = idx_err_q | (wr_acc & ~idx_ok);

`ifdef LOC_SYNC_IMMEDIATE_EN

  // Frame boundaries have no meaning when writes land directly in the active set.
  logic unused_frame_start;
  assign unused_frame_start = frame_start_i;

  assign loc_rdy_o = 1'b1;
  assign pending_o = 1'b0;

  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would otherwise infer a latch.
    active_d = active_q;
    commit_d = wr_ok;
    for (int k = 0; k < N_LIGHTS; k++) begin
      if (wr_ok && (idx_ext == CMP_W'(k))) begin
        active_d[k] = wr_pos;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the position registers are reset explicitly, because the
      // outputs must read as zero straight after reset.
      for (int k = 0; k < N_LIGHTS; k++) begin
        active_q[k] <= '0;
      end
      commit_q  <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // flop samples values from before the edge.
      active_q  <= active_d;
      commit_q  <= commit_d;
      idx_err_q <= idx_err_d;
    end
  end

`else

  // IDLE    : shadow equals active; nothing to commit.
  // PENDING : the shadow set holds at least one uncommitted write.
  // COMMIT  : a frame boundary was seen. The shadow set is copied on the edge
  //           that leaves this state, and writes are held off for this cycle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_t;

  state_t state_q, state_d;
  pos_t   shadow_q [N_LIGHTS];
  pos_t   shadow_d [N_LIGHTS];

  // Both outputs are decoded from the state only. loc_rdy_o therefore has no
  // combinational path from loc_vld_i.
  assign loc_rdy_o = (state_q != ST_COMMIT);
  assign pending_o = (state_q != ST_IDLE);

  always_comb begin
    // NOTE: every always_comb output gets a default first; a path that leaves
    // one unassigned would otherwise infer a latch.
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    commit_d = 1'b0;

    for (int k = 0; k < N_LIGHTS; k++) begin
      if (wr_ok && (idx_ext == CMP_W'(k))) begin
        shadow_d[k] = wr_pos;
      end
    end

    unique case (state_q)
      ST_IDLE: begin
        // A frame boundary with nothing new in the shadow set is not a commit.
        // A write in the boundary cycle joins the commit it triggers.
        if (wr_ok) begin
          state_d = frame_start_i ? ST_COMMIT : ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (frame_start_i) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        // A frame_start_i pulse seen here is dropped, not queued.
        state_d  = ST_IDLE;
        active_d = shadow_q;
        commit_d = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the position registers are reset explicitly, because the
      // outputs must read as zero straight after reset. Reset also cancels a
      // copy that is in progress, so the active set stays at zero.
      for (int k = 0; k < N_LIGHTS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
      state_q   <= ST_IDLE;
      commit_q  <= 1'b0;
      idx_err_q <= 1'b0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every
      // flop samples values from before the edge.
      shadow_q  <= shadow_d;
      active_q  <= active_d;
      state_q   <= state_d;
      commit_q  <= commit_d;
      idx_err_q <= idx_err_d;
    end
  end

`endif

  assign commit_o  = commit_q;
  assign idx_err_o = idx_err_q;

  always_comb begin
    loc_x_o = '0;
    loc_y_o = '0;
    loc_z_o = '0;
    for (int k = 0; k < N_LIGHTS; k++) begin
      loc_x_o[k*LOC_WIDTH +: LOC_WIDTH] = active_q[k].x;
      loc_y_o[k*LOC_WIDTH +: LOC_WIDTH] = active_q[k].y;
      loc_z_o[k*LOC_WIDTH +: LOC_WIDTH] = active_q[k].z;
    end
  end

endmodule

// File: tb/tb_light_loc_sync.sv
// -----------------------------------------------------------------------------
// tb_light_loc_sync
//
// Purpose
//   Self-checking bench for light_loc_sync in its default (frame-synchronous)
//   build. The bench keeps a reference model of the behaviour: a shadow table,
//   an active table, a "shadow is dirty" flag and a "copy on next edge" flag.
//   The model advances once per clock edge. A compare process checks every
//   output against the model on each falling edge. Directed scenarios use
//   hand-computed literal values to pin the model. After them, a long run of
//   random traffic follows.
//
//   The index width is set to 3 so that indices past N_LIGHTS can be driven.
// -----------------------------------------------------------------------------
module tb_light_loc_sync;

  localparam int LW = 10;
  localparam int NL = 4;
  localparam int IW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [LW-1:0]     loc_x_i = '0, loc_y_i = '0, loc_z_i = '0;
  logic [IW-1:0]     loc_idx_i = '0;
  logic              loc_vld_i = 1'b0;
  logic              loc_rdy_o;
  logic              frame_start_i = 1'b0;
  logic [NL*LW-1:0]  loc_x_o, loc_y_o, loc_z_o;
  logic              pending_o, commit_o, idx_err_o;

  always #5 clk = ~clk;

  light_loc_sync #(.LOC_WIDTH(LW), .N_LIGHTS(NL), .IDX_WIDTH(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .loc_x_i      (loc_x_i),
    .loc_y_i      (loc_y_i),
    .loc_z_i      (loc_z_i),
    .loc_idx_i    (loc_idx_i),
    .loc_vld_i    (loc_vld_i),
    .loc_rdy_o    (loc_rdy_o),
    .frame_start_i(frame_start_i),
    .loc_x_o      (loc_x_o),
    .loc_y_o      (loc_y_o),
    .loc_z_o      (loc_z_o),
    .pending_o    (pending_o),
    .commit_o     (commit_o),
    .idx_err_o    (idx_err_o)
  );

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [LW-1:0] m_sx [NL], m_sy [NL], m_sz [NL];
  logic [LW-1:0] m_ax [NL], m_ay [NL], m_az [NL];
  bit m_dirty;   // shadow holds writes not yet copied to active
  bit m_copy;    // frame boundary seen; the copy happens on the next edge
  bit m_commit;  // the active set loaded on the previous edge
  bit m_err;

  task automatic model_step();
    if (!rst_n) begin
      for (int k = 0; k < NL; k++) begin
        m_sx[k] = '0; m_sy[k] = '0; m_sz[k] = '0;
        m_ax[k] = '0; m_ay[k] = '0; m_az[k] = '0;
      end
      m_dirty = 0; m_copy = 0; m_commit = 0; m_err = 0;
    end else if (m_copy) begin
      // Writes are refused and frame pulses are ignored during the copy cycle.
      for (int k = 0; k < NL; k++) begin
        m_ax[k] = m_sx[k]; m_ay[k] = m_sy[k]; m_az[k] = m_sz[k];
      end
      m_copy = 0; m_dirty = 0; m_commit = 1;
    end else begin
      m_commit = 0;
      if (loc_vld_i) begin
        if (int'(loc_idx_i) < NL) begin
          m_sx[loc_idx_i] = loc_x_i;
          m_sy[loc_idx_i] = loc_y_i;
          m_sz[loc_idx_i] = loc_z_i;
          m_dirty = 1;
        end else begin
          m_err = 1;
        end
      end
      if (frame_start_i && m_dirty) m_copy = 1;
    end
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("rdy", 64'(loc_rdy_o), 64'(!m_copy));
      check("pending", 64'(pending_o), 64'(m_dirty));
      check("commit", 64'(commit_o), 64'(m_commit));
      check("idx_err", 64'(idx_err_o), 64'(m_err));
      for (int k = 0; k < NL; k++) begin
        check($sformatf("x[%0d]", k), 64'(loc_x_o[k*LW +: LW]), 64'(m_ax[k]));
        check($sformatf("y[%0d]", k), 64'(loc_y_o[k*LW +: LW]), 64'(m_ay[k]));
        check($sformatf("z[%0d]", k), 64'(loc_z_o[k*LW +: LW]), 64'(m_az[k]));
      end
    end
  end

  // Drive one cycle of inputs, advance the model at the edge, and return at the
  // following falling edge.
  task automatic step(input bit v, input int i, input int x, input int y, input int z,
                      input bit f, input bit r);
    loc_vld_i     = v;
    loc_idx_i     = i[IW-1:0];
    loc_x_i       = x[LW-1:0];
    loc_y_i       = y[LW-1:0];
    loc_z_i       = z[LW-1:0];
    frame_start_i = f;
    rst_n         = r;
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    @(negedge clk);
    // Reset with activity on the inputs; the reset must take priority.
    step(1, 1, 9, 9, 9, 1, 0);
    step(1, 2, 8, 8, 8, 1, 0);
    chk_en = 1'b1;
    check("lit reset x", 64'(loc_x_o), 64'd0);
    check("lit reset pending", 64'(pending_o), 64'd0);
    check("lit reset rdy", 64'(loc_rdy_o), 64'd1);

    // Write channel 1 with no frame pulse: only the shadow set changes.
    step(1, 1, 5, 6, 7, 0, 1);
    check("lit w1 x1", 64'(loc_x_o[1*LW +: LW]), 64'd0);
    check("lit w1 pending", 64'(pending_o), 64'd1);
    check("lit w1 rdy", 64'(loc_rdy_o), 64'd1);

    // Frame pulse: the active set loads two edges later.
    step(0, 0, 0, 0, 0, 1, 1);
    check("lit fs1 rdy", 64'(loc_rdy_o), 64'd0);
    check("lit fs1 x1 early", 64'(loc_x_o[1*LW +: LW]), 64'd0);
    idle();
    check("lit fs2 x1", 64'(loc_x_o[1*LW +: LW]), 64'd5);
    check("lit fs2 y1", 64'(loc_y_o[1*LW +: LW]), 64'd6);
    check("lit fs2 z1", 64'(loc_z_o[1*LW +: LW]), 64'd7);
    check("lit fs2 commit", 64'(commit_o), 64'd1);
    check("lit fs2 pending", 64'(pending_o), 64'd0);
    idle();
    check("lit commit one cycle", 64'(commit_o), 64'd0);

    // A write in the same cycle as the frame pulse joins that commit.
    step(1, 0, 1, 1, 1, 1, 1);
    check("lit same-cycle rdy", 64'(loc_rdy_o), 64'd0);
    idle();
    check("lit same-cycle x0", 64'(loc_x_o[0*LW +: LW]), 64'd1);
    check("lit same-cycle rdy back", 64'(loc_rdy_o), 64'd1);

    // Two writes to one channel: the last write wins.
    step(1, 2, 3, 3, 3, 0, 1);
    step(1, 2, 9, 9, 9, 0, 1);
    step(0, 0, 0, 0, 0, 1, 1);
    idle();
    check("lit lww x2", 64'(loc_x_o[2*LW +: LW]), 64'd9);
    idle();

    // An out-of-range index sets the sticky error and nothing else.
    step(1, 7, 33, 33, 33, 0, 1);
    check("lit oor err", 64'(idx_err_o), 64'd1);
    check("lit oor pending", 64'(pending_o), 64'd0);
    step(0, 0, 0, 0, 0, 1, 1);
    idle();
    check("lit oor no commit", 64'(commit_o), 64'd0);
    check("lit oor err sticky", 64'(idx_err_o), 64'd1);

    // Reset during COMMIT cancels the copy.
    step(1, 3, 4, 4, 4, 1, 1);
    check("lit pre-abort rdy", 64'(loc_rdy_o), 64'd0);
    step(0, 0, 0, 0, 0, 0, 0);
    idle();
    check("lit abort x", 64'(loc_x_o), 64'd0);
    check("lit abort commit", 64'(commit_o), 64'd0);
    check("lit abort pending", 64'(pending_o), 64'd0);
    check("lit abort err", 64'(idx_err_o), 64'd0);

    // Random traffic checked by the model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 1) == 1, int'($urandom_range(0, 7)),
           int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)),
           int'($urandom_range(0, 1023)), $urandom_range(0, 3) == 0,
           $urandom_range(0, 49) != 0);
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
